// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and per-stage
// enable/flush control bundles.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN = '{en: 1'b1, flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. x0 is never a real dependency.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic              mem_read,
  input  logic [REG_AW-1:0] rd,
  output logic              load_use
);

  logic rd_nonzero;
  logic hit_rs1;
  logic hit_rs2;

  assign rd_nonzero = |rd;
  assign hit_rs1    = use_rs1 && (rs1 == rd);
  assign hit_rs2    = use_rs2 && (rs2 == rd);
  assign load_use   = mem_read && rd_nonzero && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the five-stage pipeline: drives PC and
// inter-stage register enables/flushes, the data-memory handshake and a stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int TMO_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_ifid_rs1,
  input  logic [REG_AW-1:0] i_ifid_rs2,
  input  logic              i_ifid_use_rs1,
  input  logic              i_ifid_use_rs2,
  input  logic              i_idex_mem_read,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic              i_ex_redirect,
  input  logic              i_exmem_mem_req,
  input  logic              i_dmem_ack,
  output logic              o_dmem_req,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_idex_en,
  output logic              o_exmem_en,
  output logic              o_memwb_en,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_exmem_flush,
  output logic              o_memwb_flush,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam int TW = $clog2(TMO_CYCLES + 1);

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic            load_use;
  logic            timeout;
  logic            mem_stall;
  logic            lu_stall;
  logic            pc_en;
  logic            dmem_req;
  pipe_ctl_t       ifid_ctl;
  pipe_ctl_t       idex_ctl;
  pipe_ctl_t       exmem_ctl;
  pipe_ctl_t       memwb_ctl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .rs1      (i_ifid_rs1),
    .rs2      (i_ifid_rs2),
    .use_rs1  (i_ifid_use_rs1),
    .use_rs2  (i_ifid_use_rs2),
    .mem_read (i_idex_mem_read),
    .rd       (i_idex_rd),
    .load_use (load_use)
  );

  // A timed-out access completes (as a bubble) rather than stalling again.
  assign timeout   = (state == WAIT) && !i_dmem_ack && (tmo_cnt == TW'(TMO_CYCLES));
  assign mem_stall = ((state == IDLE) && i_exmem_mem_req && !i_dmem_ack) ||
                     ((state == WAIT) && !i_dmem_ack && !timeout);
  assign lu_stall  = load_use && !mem_stall && !i_ex_redirect;

  // Outputs sit at their reset values while reset is held, whatever the inputs.
  always_comb begin
    pc_en     = 1'b1;
    ifid_ctl  = CTL_RUN;
    idex_ctl  = CTL_RUN;
    exmem_ctl = CTL_RUN;
    memwb_ctl = CTL_RUN;
    dmem_req  = 1'b0;
    if (i_rst_n) begin
      dmem_req = (state == WAIT) || i_exmem_mem_req;
      if (mem_stall) begin
        pc_en           = 1'b0;
        ifid_ctl.en     = 1'b0;
        idex_ctl.en     = 1'b0;
        exmem_ctl.en    = 1'b0;
        memwb_ctl.flush = 1'b1;
      end else begin
        if (i_ex_redirect) begin
          ifid_ctl.flush = 1'b1;
          idex_ctl.flush = 1'b1;
        end else if (load_use) begin
          pc_en          = 1'b0;
          ifid_ctl.en    = 1'b0;
          idex_ctl.flush = 1'b1;
        end
        if (timeout) begin
          exmem_ctl.flush = 1'b1;
        end
      end
    end
  end

  assign o_dmem_req    = dmem_req;
  assign o_pc_en       = pc_en;
  assign o_ifid_en     = ifid_ctl.en;
  assign o_idex_en     = idex_ctl.en;
  assign o_exmem_en    = exmem_ctl.en;
  assign o_memwb_en    = memwb_ctl.en;
  assign o_ifid_flush  = ifid_ctl.flush;
  assign o_idex_flush  = idex_ctl.flush;
  assign o_exmem_flush = exmem_ctl.flush;
  assign o_memwb_flush = memwb_ctl.flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      o_mem_err   <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_exmem_mem_req && !i_dmem_ack) begin
            state   <= WAIT;
            tmo_cnt <= TW'(1);
          end
        end
        WAIT: begin
          if (i_dmem_ack) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if (timeout) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            o_mem_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
      endcase
      if (mem_stall || lu_stall) begin
        o_stall_cnt <= sat_inc(o_stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TMO_CYCLES=4 and a 3-bit stall
// counter so that saturation is reached within the directed sequence.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int TMO    = 4;
  localparam int CNT_W  = 3;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  localparam logic [8:0] C_RUN = 9'b11111_0000;
  localparam logic [8:0] C_MEM = 9'b00001_0001;
  localparam logic [8:0] C_LU  = 9'b00111_0100;
  localparam logic [8:0] C_RDR = 9'b11111_1100;
  localparam logic [8:0] C_TMO = 9'b11111_0010;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              use_rs1, use_rs2, mem_read, redirect, mem_req, ack;
  logic              dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_fl, idex_fl, exmem_fl, memwb_fl, mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [8:0]        ctl;

  int n_checks = 0;
  int n_errors = 0;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl};

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .TMO_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ifid_rs1      (rs1),
    .i_ifid_rs2      (rs2),
    .i_ifid_use_rs1  (use_rs1),
    .i_ifid_use_rs2  (use_rs2),
    .i_idex_mem_read (mem_read),
    .i_idex_rd       (rd),
    .i_ex_redirect   (redirect),
    .i_exmem_mem_req (mem_req),
    .i_dmem_ack      (ack),
    .o_dmem_req      (dmem_req),
    .o_pc_en         (pc_en),
    .o_ifid_en       (ifid_en),
    .o_idex_en       (idex_en),
    .o_exmem_en      (exmem_en),
    .o_memwb_en      (memwb_en),
    .o_ifid_flush    (ifid_fl),
    .o_idex_flush    (idex_fl),
    .o_exmem_flush   (exmem_fl),
    .o_memwb_flush   (memwb_fl),
    .o_mem_err       (mem_err),
    .o_stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1 = '0; rs2 = '0; rd = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; mem_read = 1'b0;
    redirect = 1'b0; mem_req = 1'b0; ack = 1'b0;
  endtask

  initial begin
    clr();
    rst_n   = 1'b0;
    mem_req = 1'b1;
    #3;
    chk("rst_ctl", 32'(ctl), 32'(C_RUN));
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    clr();
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_RUN));

    // load-use on rs1
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; use_rs1 = 1'b1;
    #1 chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs1_cnt", 32'(stall_cnt), 1);
    // load into x0 is no hazard
    rd = 5'd0; rs1 = 5'd0;
    #1 chk("lu_x0_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    // load-use on rs2
    rs1 = 5'd0; use_rs1 = 1'b0; rd = 5'd7; rs2 = 5'd7; use_rs2 = 1'b1;
    #1 chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs2_cnt", 32'(stall_cnt), 2);
    // matching rs1 but not read
    rs1 = 5'd7; use_rs1 = 1'b0; rs2 = 5'd3; use_rs2 = 1'b1;
    #1 chk("lu_nouse_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    // redirect overrides load-use
    rs1 = 5'd5; use_rs1 = 1'b1; rd = 5'd5; redirect = 1'b1;
    #1 chk("rdr_lu_ctl", 32'(ctl), 32'(C_RDR));
    tick();
    chk("rdr_lu_cnt", 32'(stall_cnt), 2);
    clr();

    // memory wait, ack on 3rd WAIT cycle
    mem_req = 1'b1;
    #1 chk("mw_idle_ctl", 32'(ctl), 32'(C_MEM));
    chk("mw_idle_req", 32'(dmem_req), 1);
    tick();
    chk("mw_w1_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    redirect = 1'b1; mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; use_rs1 = 1'b1;
    #1 chk("mw_w2_rdr_ignored", 32'(ctl), 32'(C_MEM));
    tick();
    redirect = 1'b0; mem_read = 1'b0; ack = 1'b1;
    #1 chk("mw_ack_ctl", 32'(ctl), 32'(C_RUN));
    chk("mw_ack_req", 32'(dmem_req), 1);
    tick();
    clr();
    #1 chk("mw_done_req", 32'(dmem_req), 0);
    chk("mw_done_cnt", 32'(stall_cnt), 5);
    chk("mw_done_err", 32'(mem_err), 0);

    // zero-wait access
    mem_req = 1'b1; ack = 1'b1;
    #1 chk("zw_ctl", 32'(ctl), 32'(C_RUN));
    tick();
    mem_req = 1'b0; ack = 1'b0;
    #1 chk("zw_idle_req", 32'(dmem_req), 0);
    chk("zw_cnt", 32'(stall_cnt), 5);

    // timeout with no ack; counter saturates at 7
    mem_req = 1'b1;
    #1 chk("to_idle_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("to_w1_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    tick();
    chk("to_w3_ctl", 32'(ctl), 32'(C_MEM));
    tick();
    chk("to_w4_ctl", 32'(ctl), 32'(C_TMO));
    chk("to_w4_err", 32'(mem_err), 0);
    tick();
    mem_req = 1'b0;
    #1 chk("to_after_req", 32'(dmem_req), 0);
    chk("to_after_ctl", 32'(ctl), 32'(C_RUN));
    chk("to_after_err", 32'(mem_err), 1);
    chk("to_sat_cnt", 32'(stall_cnt), 7);
    tick();
    tick();
    chk("to_err_sticky", 32'(mem_err), 1);

    // async reset while in WAIT
    mem_req = 1'b1;
    tick();
    chk("rw_wait_ctl", 32'(ctl), 32'(C_MEM));
    #2 rst_n = 1'b0;
    #1 chk("rw_ctl", 32'(ctl), 32'(C_RUN));
    chk("rw_req", 32'(dmem_req), 0);
    chk("rw_err", 32'(mem_err), 0);
    chk("rw_cnt", 32'(stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    #1 chk("rw_fresh_idle", 32'(ctl), 32'(C_MEM));
    tick();
    tick();
    tick();
    chk("rw_fresh_w3", 32'(ctl), 32'(C_MEM));
    tick();
    chk("rw_fresh_w4", 32'(ctl), 32'(C_TMO));
    chk("rw_fresh_cnt", 32'(stall_cnt), 4);
    tick();
    chk("rw_fresh_err", 32'(mem_err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
